muldiv_e: RTL and testbench
===========================

Name: muldiv_e

Overview:
- Execute-stage M-extension unit. It consumes the decode-to-execute register's operands, after the forwarding muxes, and produces a 32-bit product, quotient or remainder.
- Multi-cycle and iterative: it holds the pipeline via a combinational busy output to the hazard unit.
- Its result is muxed with the ALU result into the execute-to-memory register on the done cycle.

Parameters:
- XLEN, 32, operand/result width; only 32 is supported.
- ITER, 32, iteration cycles for the iterative mul/div (equals XLEN).

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  asynchronous, active-low reset.
- start_i  in  1  M-type instruction present in E (level; held while stalled).
- op_i  in  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- a_i  in  XLEN  forwarded rs1 value.
- b_i  in  XLEN  forwarded rs2 value.
- clr_i  in  1  synchronous abort, same as the E-register flush.
- busy_o  out  1  stall request to the hazard unit (combinational).
- done_o  out  1  result valid this cycle.
- result_o  out  XLEN  registered result.

Behaviour:
- Reset (rst_ni low, asynchronous): state IDLE, result_o=0, done_o=0, all internal accumulators and counter 0.
- States:
  - IDLE: no operation in progress.
  - CALC: iterating.
  - DONE: result presented for one cycle.
- IDLE, start_i=1:
  - Latch op_i.
  - Latch the operand magnitudes; signed ops take abs values, MULHSU only takes abs(a).
  - Latch the sign-fix flags.
  - Set counter=ITER-1 and go to CALC.
  - busy_o=1 combinationally in this same cycle.
- Division special cases in IDLE go directly to DONE with result_o loaded that edge:
  - b=0: DIV/DIVU give all-ones; REM/REMU give a_i.
  - DIV/REM with a=0x8000_0000, b=0xFFFF_FFFF: DIV gives 0x8000_0000, REM gives 0.
- CALC, one step per cycle:
  - Multiply: shift-add into a 64-bit product.
  - Divide: restoring step on a 64-bit remainder:quotient pair.
  - busy_o=1.
  - At counter=0: apply sign correction, load result_o, go to DONE.
  - MUL returns low word; MULH/MULHSU/MULHU return high word.
  - DIV/DIVU return quotient; REM/REMU return remainder. Remainder sign follows the dividend.
- DONE:
  - done_o=1, busy_o=0, so the pipeline advances at the end of this cycle.
  - start_i is ignored because it is still the same instruction.
  - Next state is IDLE unconditionally.
- Latency: normal op keeps the instruction in E for 1 (start) + 32 (CALC) + 1 (DONE) = 34 cycles. Special-case divide takes 2 cycles.
- Back-to-back M ops: the second starts in the IDLE cycle after DONE. No bubble is inserted beyond that.
- clr_i=1 in any state: next state IDLE, done_o=0, result_o unchanged; busy_o=0 in that cycle. clr_i has priority over start_i.
- Reset mid-CALC: immediate return to IDLE with no done_o pulse.
- busy_o = (state==IDLE & start_i & ~clr_i) | (state==CALC & ~clr_i).
- result_o holds its value outside DONE. Consumers qualify it with done_o.

Optional Feature:
- Macro: MULDIV_FAST_MUL_EN.
- Defined: all four multiply ops use a combinational 33x33 signed multiply in IDLE and go IDLE→DONE, so occupancy is 2 cycles. Divide is unchanged.
- Undefined: multiply uses the 32-cycle shift-add path. No multiplier is inferred.

Decomposition:
- Shared package muldiv_pkg:
  - muldiv_op_e enum for the eight funct3 codes.
  - muldiv_state_e (IDLE, CALC, DONE).
  - Constants XLEN_C=32, DIV_ZERO_Q='1, INT_MIN=32'h8000_0000.
- Natural sub-module: muldiv_sign_fix, combinational. Inputs: raw 64-bit pair, op, sign flags. Output: final 32-bit result. It is reused by both the mul and div paths.

Test Plan:
- MUL a=7, b=-3 (0xFFFF_FFFD): busy_o high 33 cycles from start, done_o on cycle 34, result_o=0xFFFF_FFEB; with MULDIV_FAST_MUL_EN, done_o on cycle 2 with the same value.
- MULHU a=b=0xFFFF_FFFF → 0xFFFF_FFFE. MULH same operands → 0x0000_0000. MULHSU a=-1, b=0xFFFF_FFFF → 0xFFFF_FFFF.
- DIV a=-20, b=6 → 0xFFFF_FFFD (-3). REM → 0xFFFF_FFFE (-2). DIVU a=20, b=6 → 3. REMU → 2.
- DIVU a=5, b=0 → done_o in cycle 2, 0xFFFF_FFFF. REM a=5, b=0 → 5. DIV 0x8000_0000 / -1 → 0x8000_0000. REM of the same operands → 0.
- Start DIV, pulse clr_i at CALC cycle 10 → busy_o low the same cycle, IDLE next, no done_o. Repeat with rst_ni low mid-CALC → outputs 0 asynchronously.
- Two DIVUs held back-to-back on start_i (100/7, then 9/3) → results 14 and 3, each with a single done_o, and the second busy_o begins the cycle after the first DONE.

Source files
------------

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared types and constants for the execute-stage M unit.
// Op codes follow funct3 of the RV32M instructions.
package muldiv_pkg;

  localparam int XLEN_C = 32;
  localparam int ITER_C = 32;
  localparam logic [31:0] DIV_ZERO_Q = '1;
  localparam logic [31:0] INT_MIN = 32'h8000_0000;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } muldiv_state_e;

  // rs1 is treated as signed
  function automatic logic a_signed(muldiv_op_e op);
    return (op == OP_MUL) || (op == OP_MULH) ||
           (op == OP_MULHSU) || (op == OP_DIV) ||
           (op == OP_REM);
  endfunction

  // rs2 is treated as signed
  function automatic logic b_signed(muldiv_op_e op);
    return (op == OP_MUL) || (op == OP_MULH) ||
           (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/muldiv_sign_fix.sv
// muldiv_sign_fix: picks the result word from the raw 64-bit pair
// and restores the sign; shared by the multiply and divide paths.
module muldiv_sign_fix
  import muldiv_pkg::*;
(
  input  logic [63:0] raw_i,
  input  muldiv_op_e  op_i,
  input  logic        neg_i,
  output logic [31:0] res_o
);

  logic [63:0] prod;
  logic [31:0] word;

  // product negated as a whole; quotient/remainder per word
  always_comb begin
    prod  = neg_i ? -raw_i : raw_i;
    word  = op_i[1] ? raw_i[63:32] : raw_i[31:0];
    res_o = prod[63:32];
    if (op_i[2]) begin
      res_o = neg_i ? -word : word;
    end else if (op_i == OP_MUL) begin
      res_o = prod[31:0];
    end
  end

endmodule

// File: rtl/muldiv_e.sv
// muldiv_e: iterative RV32M multiply/divide unit in the E stage.
// Define MULDIV_FAST_MUL_EN for a single-cycle 33x33 multiply.
module muldiv_e
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int ITER = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            start_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic            clr_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  localparam int CW = $clog2(ITER);

  muldiv_state_e   state_q, state_d;
  muldiv_op_e      op_q, op_in;
  logic [XLEN-1:0]   m_q;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [CW-1:0]     cnt_q;
  logic              neg_q;
  logic [XLEN-1:0]   result_q;

  logic            a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            is_div, is_rem;
  logic            div_zero, div_ovf;
  logic            special;
  logic [XLEN-1:0] spec_res;
  logic            fast_hit;
  logic [XLEN-1:0] fast_res;
  logic [XLEN-1:0] fix_res;

  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_rem;
  logic [XLEN:0]     div_diff;
  logic [2*XLEN-1:0] mul_nxt, div_nxt;

  assign op_in = muldiv_op_e'(op_i);

  // operand magnitudes and short-cut results at issue
  always_comb begin
    a_neg    = a_signed(op_in) & a_i[XLEN-1];
    b_neg    = b_signed(op_in) & b_i[XLEN-1];
    a_mag    = a_neg ? -a_i : a_i;
    b_mag    = b_neg ? -b_i : b_i;
    is_div   = op_i[2];
    is_rem   = op_i[2] & op_i[1];
    div_zero = is_div & (b_i == '0);
    div_ovf  = is_div & ~op_i[0] &
               (a_i == INT_MIN) & (b_i == '1);
    special  = div_zero | div_ovf;
    spec_res = is_rem ? '0 : INT_MIN;
    if (div_zero) begin
      spec_res = is_rem ? a_i : DIV_ZERO_Q;
    end
  end

`ifdef MULDIV_FAST_MUL_EN
  logic signed [63:0] fa, fb, fprod;

  // one-shot signed 33x33 multiply, all four mul ops
  always_comb begin
    fa       = {{32{a_neg}}, a_i};
    fb       = {{32{b_neg}}, b_i};
    fprod    = fa * fb;
    fast_hit = ~is_div;
    fast_res = (op_in == OP_MUL) ? fprod[31:0]
                                 : fprod[63:32];
  end
`else
  assign fast_hit = 1'b0;
  assign fast_res = '0;
`endif

  // one shift-add or restoring-divide step
  always_comb begin
    mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} +
              (acc_q[0] ? {1'b0, m_q} : '0);
    mul_nxt = {mul_sum, acc_q[XLEN-1:1]};
    div_rem  = acc_q[2*XLEN-1:XLEN-1];
    div_diff = div_rem - {1'b0, m_q};
    if (div_diff[XLEN]) begin
      div_nxt = {div_rem[XLEN-1:0],
                 acc_q[XLEN-2:0], 1'b0};
    end else begin
      div_nxt = {div_diff[XLEN-1:0],
                 acc_q[XLEN-2:0], 1'b1};
    end
    acc_d = op_q[2] ? div_nxt : mul_nxt;
  end

  muldiv_sign_fix u_fix (
    .raw_i (acc_d),
    .op_i  (op_q),
    .neg_i (neg_q),
    .res_o (fix_res)
  );

  // state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // next-state logic; clear wins over everything
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = (special | fast_hit) ? S_DONE
                                         : S_CALC;
        end
      end
      S_CALC: begin
        if (cnt_q == '0) begin
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (clr_i) begin
      state_d = S_IDLE;
    end
  end

  // stall and done outputs
  always_comb begin
    busy_o = 1'b0;
    done_o = 1'b0;
    if (!clr_i) begin
      busy_o = (state_q == S_CALC) ||
               ((state_q == S_IDLE) && start_i);
      done_o = (state_q == S_DONE);
    end
  end

  // operand latch, iteration and result register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      op_q     <= OP_MUL;
      m_q      <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      result_q <= '0;
    end else if (!clr_i) begin
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            op_q  <= op_in;
            neg_q <= a_neg ^ (b_neg & ~is_rem);
            m_q   <= is_div ? b_mag : a_mag;
            acc_q <= {{XLEN{1'b0}},
                      is_div ? a_mag : b_mag};
            cnt_q <= CW'(ITER - 1);
            if (special) begin
              result_q <= spec_res;
            end else if (fast_hit) begin
              result_q <= fast_res;
            end
          end
        end
        S_CALC: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == '0) begin
            result_q <= fix_res;
          end
        end
        default: ;
      endcase
    end
  end

  assign result_o = result_q;

endmodule

// File: tb/tb_muldiv_e.sv
// tb_muldiv_e: directed and random checks of muldiv_e
// against an arithmetic reference model.
module tb_muldiv_e;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = 3'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        clr = 1'b0;
  logic        busy, done;
  logic [31:0] res;

  int errors = 0;
  int checks = 0;
  logic [31:0] last_exp = '0;

  muldiv_e dut (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .start_i  (start),
    .op_i     (op),
    .a_i      (a),
    .b_i      (b),
    .clr_i    (clr),
    .busy_o   (busy),
    .done_o   (done),
    .result_o (res)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_f(
    input logic [2:0] o, input logic [31:0] x,
    input logic [31:0] y);
    longint p;
    longint unsigned up;
    logic ovf;
    ovf = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
    case (o)
      3'd0: begin
        p = longint'($signed(x)) * longint'($signed(y));
        return p[31:0];
      end
      3'd1: begin
        p = longint'($signed(x)) * longint'($signed(y));
        return p[63:32];
      end
      3'd2: begin
        p = longint'($signed(x)) * longint'(y);
        return p[63:32];
      end
      3'd3: begin
        up = longint'(x) * longint'(y);
        return up[63:32];
      end
      3'd4: begin
        if (y == 0) return 32'hFFFF_FFFF;
        if (ovf) return 32'h8000_0000;
        return $signed(x) / $signed(y);
      end
      3'd5: return (y == 0) ? 32'hFFFF_FFFF : x / y;
      3'd6: begin
        if (y == 0) return x;
        if (ovf) return 32'h0;
        return $signed(x) % $signed(y);
      end
      default: return (y == 0) ? x : x % y;
    endcase
  endfunction

  function automatic int lat_f(
    input logic [2:0] o, input logic [31:0] x,
    input logic [31:0] y);
    if (o[2]) begin
      if (y == 0) return 2;
      if (!o[0] && x == 32'h8000_0000 &&
          y == 32'hFFFF_FFFF) return 2;
      return 34;
    end
`ifdef MULDIV_FAST_MUL_EN
    return 2;
`else
    return 34;
`endif
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // issue one op; leaves start high in the DONE cycle
  task automatic run_op(input logic [2:0] o,
                        input logic [31:0] x,
                        input logic [31:0] y,
                        input string tag);
    logic [31:0] exp;
    int explat, got;
    logic bok;
    exp = ref_f(o, x, y);
    explat = lat_f(o, x, y);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    got = 0;
    bok = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      #1;
      if (done === 1'b1) begin
        got = c;
        if (busy !== 1'b0) bok = 1'b0;
        break;
      end
      if (busy !== 1'b1) bok = 1'b0;
      @(negedge clk);
    end
    chk({tag, "_lat"}, got, explat);
    chk({tag, "_busy"}, {31'b0, bok}, 32'd1);
    chk({tag, "_res"}, res, exp);
    last_exp = exp;
  endtask

  task automatic idle();
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    logic [2:0] ro;
    logic [31:0] ra, rb;
    logic seen;

    #2;
    chk("rst_res", res, 32'h0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(3'd0, 32'd7, 32'hFFFF_FFFD, "mul");
    idle();
    run_op(3'd3, '1, '1, "mulhu");
    run_op(3'd1, '1, '1, "mulh");
    run_op(3'd2, '1, '1, "mulhsu");
    idle();
    run_op(3'd4, -32'sd20, 32'd6, "div");
    run_op(3'd6, -32'sd20, 32'd6, "rem");
    run_op(3'd5, 32'd20, 32'd6, "divu");
    run_op(3'd7, 32'd20, 32'd6, "remu");
    idle();
    run_op(3'd5, 32'd5, 32'd0, "divu0");
    run_op(3'd6, 32'd5, 32'd0, "rem0");
    run_op(3'd4, 32'h8000_0000, '1, "divovf");
    run_op(3'd6, 32'h8000_0000, '1, "removf");
    idle();

    // flush during CALC cycle 10
    @(negedge clk);
    start = 1'b1; op = 3'd4; a = 32'd1000; b = 32'd7;
    repeat (10) @(negedge clk);
    #1;
    chk("clr_pre_busy", {31'b0, busy}, 32'd1);
    clr = 1'b1;
    #1;
    chk("clr_busy", {31'b0, busy}, 32'd0);
    chk("clr_done", {31'b0, done}, 32'd0);
    @(negedge clk);
    clr = 1'b0; start = 1'b0;
    #1;
    chk("clr_idle_busy", {31'b0, busy}, 32'd0);
    chk("clr_keep_res", res, last_exp);
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk); #1;
      if (done !== 1'b0) seen = 1'b1;
    end
    chk("clr_no_done", {31'b0, seen}, 32'd0);

    // reset during CALC
    @(negedge clk);
    start = 1'b1; op = 3'd5; a = 32'd12345; b = 32'd11;
    repeat (6) @(negedge clk);
    #2;
    rst_n = 1'b0; start = 1'b0;
    #1;
    chk("arst_res", res, 32'h0);
    chk("arst_done", {31'b0, done}, 32'd0);
    chk("arst_busy", {31'b0, busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk); #1;
      if (done !== 1'b0) seen = 1'b1;
    end
    chk("arst_no_done", {31'b0, seen}, 32'd0);

    // held back-to-back divides
    run_op(3'd5, 32'd100, 32'd7, "b2b_1");
    run_op(3'd5, 32'd9, 32'd3, "b2b_2");
    idle();

    for (int i = 0; i < 24; i++) begin
      ro = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 7) == 0) rb = '0;
      if ($urandom_range(0, 3) == 0) rb = rb >> 24;
      run_op(ro, ra, rb, $sformatf("rnd%0d", i));
      if ($urandom_range(0, 1) == 0) idle();
    end
    idle();

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
